// File: rtl/skip_pkg.sv
// Shared defaults, FSM state type and index-width helper for the skip ring driver.
package skip_pkg;

    localparam int unsigned DEF_LEN   = 16;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_DIV_W = 32;
    localparam logic [DEF_LEN-1:0] DEF_INIT_MASK = 16'b0011010001000101;

    localparam int unsigned SEL_W   = 5;
    localparam int unsigned DWELL_W = 8;

    typedef enum logic {
        RESYNC = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Ceiling log2, never less than 1 so a one-entry table still gets an index bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/skip_seq_if.sv
// Control/status bundle between the sequencer and its host, plus the ring-facing outputs.
interface skip_seq_if
    import skip_pkg::*;
#(
    parameter int unsigned LEN   = DEF_LEN,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned IDX_W = clog2(DEPTH);

    logic [SEL_W-1:0]   DIV_SEL;
    logic [DWELL_W-1:0] DWELL;
    logic               WR_EN;
    logic [IDX_W-1:0]   WR_ADDR;
    logic [LEN-1:0]     WR_DATA;
    logic               WR_ACK;
    logic               SLOW_CLK;
    logic               TICK;
    logic [LEN-1:0]     MASK;
    logic               RING_RST;
    logic [IDX_W-1:0]   IDX;

    modport master (
        output DIV_SEL, DWELL, WR_EN, WR_ADDR, WR_DATA,
        input  WR_ACK, SLOW_CLK, TICK, MASK, RING_RST, IDX
    );

    modport slave (
        input  DIV_SEL, DWELL, WR_EN, WR_ADDR, WR_DATA,
        output WR_ACK, SLOW_CLK, TICK, MASK, RING_RST, IDX
    );

endinterface

// File: rtl/skip_prescale.sv
// Free-running prescaler: selects one counter bit as the slow clock and flags its rising edge.
module skip_prescale
    import skip_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [SEL_W-1:0] DIV_SEL,
    output logic             SLOW_CLK,
    output logic             TICK
);

    localparam int unsigned K_W = clog2(DIV_W);

    logic [DIV_W-1:0] count_q;
    logic [K_W-1:0]   sel_c;
    logic             slow_bit_c;

    // Clamp the bit select to the counter width and pick the slow-clock bit.
    always_comb begin
        sel_c = K_W'(DIV_W - 1);
        if (32'(DIV_SEL) < DIV_W) begin
            sel_c = K_W'(DIV_SEL);
        end
        slow_bit_c = count_q[sel_c];
    end

    // Counter plus registered slow clock; TICK needs SLOW_CLK low first, so ticks are >=2 cycles apart.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q  <= '0;
            SLOW_CLK <= 1'b0;
            TICK     <= 1'b0;
        end else begin
            count_q  <= count_q + DIV_W'(1);
            SLOW_CLK <= slow_bit_c;
            TICK     <= slow_bit_c & ~SLOW_CLK;
        end
    end

endmodule

// File: rtl/skip_seq.sv
// Skip ring driver: slow clock generation, mask table, dwell sequencing and ring reset.
module skip_seq
    import skip_pkg::*;
#(
    parameter int unsigned   LEN       = DEF_LEN,
    parameter int unsigned   DIV_W     = DEF_DIV_W,
    parameter int unsigned   DEPTH     = DEF_DEPTH,
    parameter logic [LEN-1:0] INIT_MASK = LEN'(DEF_INIT_MASK)
) (
    input  logic     CLK,
    input  logic     RST,
    skip_seq_if.slave bus
);

    localparam int unsigned IDX_W = clog2(DEPTH);

    logic                 tick;
    logic                 slow_clk;

    logic [LEN-1:0]       mask_tbl_q [DEPTH];
    logic                 wr_ack_q;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_nxt_c;
    logic [LEN-1:0]       mask_q, mask_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 ring_rst_q, ring_rst_d;

    skip_prescale #(
        .DIV_W (DIV_W)
    ) u_prescale (
        .CLK      (CLK),
        .RST      (RST),
        .DIV_SEL  (bus.DIV_SEL),
        .SLOW_CLK (slow_clk),
        .TICK     (tick)
    );

    // Mask table: entry 0 resets to INIT_MASK, the rest to zero; writes acknowledged next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mask_tbl_q[i] <= (i == 0) ? INIT_MASK : '0;
            end
            wr_ack_q <= 1'b0;
        end else begin
            if (bus.WR_EN) begin
                mask_tbl_q[bus.WR_ADDR] <= bus.WR_DATA;
            end
            wr_ack_q <= bus.WR_EN;
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RESYNC;
            idx_q      <= '0;
            mask_q     <= INIT_MASK;
            dwell_q    <= '0;
            ring_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            dwell_q    <= dwell_d;
            ring_rst_q <= ring_rst_d;
        end
    end

    // Next-state logic; only tick edges move the sequencer. Advance reads write-first.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        dwell_d    = dwell_q;
        ring_rst_d = ring_rst_q;
        idx_nxt_c  = idx_q + IDX_W'(1);

        if (tick) begin
            case (state_q)
                RESYNC: begin
                    state_d    = RUN;
                    ring_rst_d = 1'b0;
                    dwell_d    = '0;
                end
                RUN: begin
                    if (bus.DWELL != '0) begin
                        if (dwell_q == bus.DWELL - DWELL_W'(1)) begin
                            idx_d      = idx_nxt_c;
                            mask_d     = (bus.WR_EN && (bus.WR_ADDR == idx_nxt_c)) ?
                                         bus.WR_DATA : mask_tbl_q[idx_nxt_c];
                            dwell_d    = '0;
                            state_d    = RESYNC;
                            ring_rst_d = 1'b1;
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = RESYNC;
                    ring_rst_d = 1'b1;
                end
            endcase
        end
    end

    // Drive the ring-facing and host-facing outputs from registers.
    assign bus.SLOW_CLK = slow_clk;
    assign bus.TICK     = tick;
    assign bus.MASK     = mask_q;
    assign bus.IDX      = idx_q;
    assign bus.RING_RST = ring_rst_q;
    assign bus.WR_ACK   = wr_ack_q;

endmodule

// File: tb/tb_skip_seq.sv
// Bench for skip_seq: vector table, corner-case sequences and a randomized tick-count model.
module tb_skip_seq;
    import skip_pkg::*;

    localparam logic [15:0] INIT = 16'h3445;

    logic CLK = 1'b0;
    logic RST;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 CLK = ~CLK;

    skip_seq_if bus ();

    skip_seq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        int unsigned div_sel;
        int unsigned dwell;
        int unsigned cyc;
        logic        slow;
        logic        tick;
        logic        rrst;
        logic [1:0]  idx;
        logic [15:0] mask;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench right after the reset edge: zero edges since release.
    task automatic do_reset(input int unsigned k, input int unsigned d);
        RST         = 1'b1;
        bus.DIV_SEL = 5'(k);
        bus.DWELL   = 8'(d);
        bus.WR_EN   = 1'b0;
        bus.WR_ADDR = 2'd0;
        bus.WR_DATA = 16'h0;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic write_one(input logic [1:0] a, input logic [15:0] d);
        bus.WR_EN   = 1'b1;
        bus.WR_ADDR = a;
        bus.WR_DATA = d;
        step();
        bus.WR_EN   = 1'b0;
    endtask

    task automatic wait_idx(input logic [1:0] want, input string name);
        bit found;
        found = (bus.IDX == want);
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            found = (bus.IDX == want);
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // Slow clock after n edges since release is bit k of (n-1).
    function automatic int slow_at(input int k, input int n);
        if (n < 1) return 0;
        return ((n - 1) >> k) & 1;
    endfunction

    function automatic int tick_at(input int k, input int n);
        if (n < 1) return 0;
        return slow_at(k, n) & (1 - slow_at(k, n - 1));
    endfunction

    // Reference: count tick edges; each mask spans one resync tick plus DWELL run ticks.
    task automatic run_random(input int k, input int d, input int cycles);
        logic [15:0] tbl [4];
        int          t;
        logic [1:0]  idx_e;
        logic [15:0] mask_e;
        logic        wr;
        logic [1:0]  wa;
        logic [15:0] wd;
        logic        rr_e;
        do_reset(32'(k), 32'(d));
        tbl[0] = INIT; tbl[1] = 16'h0; tbl[2] = 16'h0; tbl[3] = 16'h0;
        t = 0; idx_e = 2'd0; mask_e = INIT;
        for (int m = 1; m <= cycles; m++) begin
            wr = ($urandom_range(0, 2) == 0);
            wa = 2'($urandom_range(0, 3));
            wd = 16'($urandom);
            bus.WR_EN   = wr;
            bus.WR_ADDR = wa;
            bus.WR_DATA = wd;
            step();
            if (tick_at(k, m - 1) != 0) begin
                t++;
                if (d != 0 && (t % (d + 1)) == 0) begin
                    idx_e  = 2'((t / (d + 1)) % 4);
                    mask_e = (wr && wa == idx_e) ? wd : tbl[idx_e];
                end
            end
            if (wr) tbl[wa] = wd;
            rr_e = (d == 0) ? (t == 0) : ((t % (d + 1)) == 0);
            chk("rnd_slow",  32'(bus.SLOW_CLK), 32'(slow_at(k, m)));
            chk("rnd_tick",  32'(bus.TICK),     32'(tick_at(k, m)));
            chk("rnd_idx",   32'(bus.IDX),      32'(idx_e));
            chk("rnd_mask",  32'(bus.MASK),     32'(mask_e));
            chk("rnd_rrst",  32'(bus.RING_RST), 32'(rr_e));
            chk("rnd_wrack", 32'(bus.WR_ACK),   32'(wr));
        end
        bus.WR_EN = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          hi;
        int          last_tick;
        int          min_gap;
        int          align_err;
        logic        prev_slow;
        bit          same;
        bit          found;

        RST         = 1'b1;
        bus.DIV_SEL = 5'd0;
        bus.DWELL   = 8'd0;
        bus.WR_EN   = 1'b0;
        bus.WR_ADDR = 2'd0;
        bus.WR_DATA = 16'h0;

        //              k  d  cyc slow tick rrst idx mask
        vecs.push_back('{2, 0,  0, 0, 0, 1, 2'd0, INIT});
        vecs.push_back('{2, 0,  4, 0, 0, 1, 2'd0, INIT});
        vecs.push_back('{2, 0,  5, 1, 1, 1, 2'd0, INIT});
        vecs.push_back('{2, 0,  6, 1, 0, 0, 2'd0, INIT});
        vecs.push_back('{2, 0,  9, 0, 0, 0, 2'd0, INIT});
        vecs.push_back('{2, 0, 13, 1, 1, 0, 2'd0, INIT});
        vecs.push_back('{2, 0, 60, 0, 0, 0, 2'd0, INIT});
        vecs.push_back('{0, 1,  2, 1, 1, 1, 2'd0, INIT});
        vecs.push_back('{0, 1,  3, 0, 0, 0, 2'd0, INIT});
        vecs.push_back('{0, 1,  5, 0, 0, 1, 2'd1, 16'h0});
        vecs.push_back('{0, 1, 15, 0, 0, 0, 2'd3, 16'h0});
        vecs.push_back('{0, 1, 17, 0, 0, 1, 2'd0, INIT});
        vecs.push_back('{0, 3,  9, 0, 0, 1, 2'd1, 16'h0});
        vecs.push_back('{1, 2, 12, 1, 0, 1, 2'd1, 16'h0});

        foreach (vecs[i]) begin
            do_reset(vecs[i].div_sel, vecs[i].dwell);
            repeat (vecs[i].cyc) step();
            chk($sformatf("vec%0d_slow", i), 32'(bus.SLOW_CLK), 32'(vecs[i].slow));
            chk($sformatf("vec%0d_tick", i), 32'(bus.TICK),     32'(vecs[i].tick));
            chk($sformatf("vec%0d_rrst", i), 32'(bus.RING_RST), 32'(vecs[i].rrst));
            chk($sformatf("vec%0d_idx",  i), 32'(bus.IDX),      32'(vecs[i].idx));
            chk($sformatf("vec%0d_mask", i), 32'(bus.MASK),     32'(vecs[i].mask));
            chk($sformatf("vec%0d_ack",  i), 32'(bus.WR_ACK),   32'd0);
        end

        // Write entry 1, then watch the first advance and the ring reset width.
        do_reset(0, 3);
        write_one(2'd1, 16'h00FF);
        chk("wr_ack_pulse", 32'(bus.WR_ACK), 32'd1);
        step();
        chk("wr_ack_drop", 32'(bus.WR_ACK), 32'd0);
        wait_idx(2'd1, "adv_timeout");
        chk("adv_mask", 32'(bus.MASK), 32'h00FF);
        chk("adv_rrst", 32'(bus.RING_RST), 32'd1);
        hi = 1;
        for (int i = 0; i < 50 && bus.RING_RST; i++) begin
            step();
            if (bus.RING_RST) hi++;
        end
        chk("rrst_width", 32'(hi), 32'd2);

        // Write to the active entry mid-dwell: visible only after the table wraps back.
        do_reset(0, 4);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            found = !bus.RING_RST;
        end
        chk("run_timeout", 32'(found), 32'd1);
        write_one(2'd0, 16'hAAAA);
        same = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.MASK !== INIT || bus.IDX !== 2'd0) same = 1'b0;
            step();
        end
        chk("active_write_hold", 32'(same), 32'd1);
        wait_idx(2'd3, "wrap3_timeout");
        wait_idx(2'd0, "wrap0_timeout");
        chk("active_write_seen", 32'(bus.MASK), 32'hAAAA);

        // Write and advance to the same entry on the same edge.
        do_reset(0, 1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            found = bus.TICK && !bus.RING_RST && (bus.IDX == 2'd0);
        end
        chk("coll_timeout", 32'(found), 32'd1);
        write_one(2'd1, 16'h5A5A);
        chk("coll_idx",  32'(bus.IDX),  32'd1);
        chk("coll_mask", 32'(bus.MASK), 32'h5A5A);

        // Reset in the middle of a run clears the table.
        do_reset(0, 1);
        write_one(2'd1, 16'h1111);
        write_one(2'd2, 16'h2222);
        write_one(2'd3, 16'h3333);
        wait_idx(2'd2, "pre_rst_timeout");
        chk("pre_rst_mask", 32'(bus.MASK), 32'h2222);
        RST = 1'b1;
        step();
        chk("mid_rst_idx",  32'(bus.IDX),      32'd0);
        chk("mid_rst_mask", 32'(bus.MASK),     32'(INIT));
        chk("mid_rst_rrst", 32'(bus.RING_RST), 32'd1);
        chk("mid_rst_slow", 32'(bus.SLOW_CLK), 32'd0);
        chk("mid_rst_tick", 32'(bus.TICK),     32'd0);
        RST = 1'b0;
        wait_idx(2'd1, "post_rst1_timeout");
        chk("cleared_e1", 32'(bus.MASK), 32'd0);
        wait_idx(2'd2, "post_rst2_timeout");
        chk("cleared_e2", 32'(bus.MASK), 32'd0);
        wait_idx(2'd3, "post_rst3_timeout");
        chk("cleared_e3", 32'(bus.MASK), 32'd0);

        // DIV_SEL change mid-run: tick spacing and tick/slow-clock alignment.
        do_reset(3, 0);
        last_tick = -100;
        min_gap   = 1000;
        align_err = 0;
        prev_slow = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            if (c == 45) bus.DIV_SEL = 5'd0;
            if (c == 80) bus.DIV_SEL = 5'd2;
            step();
            if (bus.TICK !== (bus.SLOW_CLK & ~prev_slow)) align_err++;
            if (bus.TICK) begin
                if (c - last_tick < min_gap) min_gap = c - last_tick;
                last_tick = c;
            end
            prev_slow = bus.SLOW_CLK;
        end
        chk("divchg_min_gap_ok", 32'(min_gap >= 2), 32'd1);
        chk("divchg_align", 32'(align_err), 32'd0);

        for (int r = 0; r < 6; r++) begin
            run_random(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 160);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/skip_seq.md
# skip_seq

Upstream driver for the skip ring: it divides the board clock into the slow ring clock and sequences a small writable table of skip masks. Each mask is held for a programmable number of slow ticks. When the mask changes, the block asserts a ring reset spanning one slow-clock rising edge, so the ring restarts aligned to the new mask. Its outputs connect directly to the ring's iCLK, RST and MASK inputs.

## Interface
- LEN, 16: mask width; must match the ring's LEN.
- DIV_W, 32: prescaler counter width.
- DEPTH, 4: mask table entries; power of two.
- INIT_MASK, 16'b0011010001000101: reset contents of entry 0.

- CLK  in  1  board clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- DIV_SEL  in  5  counter bit used as the slow clock; values ≥ DIV_W clamp to DIV_W-1.
- DWELL  in  8  slow ticks per mask; 0 holds the current mask indefinitely.
- WR_EN  in  1  table write strobe.
- WR_ADDR  in  log2(DEPTH)  table write address.
- WR_DATA  in  LEN  table write data.
- WR_ACK  out  1  one-cycle pulse acknowledging a write.
- SLOW_CLK  out  1  registered slow clock; drives the ring's iCLK.
- TICK  out  1  one-cycle pulse marking each SLOW_CLK rising edge.
- MASK  out  LEN  active mask; drives the ring's MASK.
- RING_RST  out  1  ring reset; drives the ring's RST.
- IDX  out  log2(DEPTH)  active table index.

## Operation
- Prescaler:
  - counter increments every cycle and wraps at 2^DIV_W.
  - SLOW_CLK <= counter[k], where k is the clamped DIV_SEL.
  - TICK <= counter[k] & ~SLOW_CLK, so TICK rises together with SLOW_CLK.
- Table: DEPTH×LEN registers.
  - On reset, entry 0 = INIT_MASK; all other entries = 0.
  - A write lands on the edge WR_EN is sampled. WR_ACK is high the following cycle.
- A "tick edge" is a CLK edge sampled while TICK=1. All sequencing happens on tick edges.
- FSM states: RESYNC and RUN.
  - RESYNC: RING_RST=1. On a tick edge: go to RUN, set RING_RST=0, set dwell_cnt=0.
  - RUN, DWELL≠0, tick edge with dwell_cnt==DWELL-1 (advance):
    - IDX <= IDX+1, wrapping DEPTH-1 → 0.
    - MASK <= table[IDX+1].
    - dwell_cnt <= 0; go to RESYNC with RING_RST=1.
  - RUN, any other tick edge: dwell_cnt++.
  - RUN, DWELL=0: dwell_cnt frozen; no advance.
- MASK is a register, loaded only on advance or reset.
  - A write to the active entry does not change MASK until that entry is next selected.
  - If a write and an advance hit the same entry on the same edge, the new data is loaded (write-first).
- DWELL lowered below dwell_cnt mid-run: the count keeps going and wraps at 256, then matches. No special handling.
- An all-zero mask is output as-is; it is not skipped.

## Timing
- Reset values:
  - counter=0, SLOW_CLK=0, TICK=0, WR_ACK=0.
  - IDX=0, MASK=INIT_MASK, RING_RST=1, state=RESYNC.
- With n cycles after RST release and k=DIV_SEL:
  - SLOW_CLK equals bit k of (n-1).
  - First TICK occurs at n=2^k+1; TICK period is 2^(k+1) cycles.
- RING_RST stays high through the CLK edge where SLOW_CLK rises, and drops one cycle later. This gives the ring one clean sampled reset edge.
- MASK, IDX and RING_RST change one CLK cycle after the SLOW_CLK rising edge. They are therefore stable before the next rising edge.
- DIV_SEL change mid-run: one slow period may be shortened or lengthened. Two TICKs are never fewer than 2 cycles apart, and no glitch appears on SLOW_CLK.
- RST mid-operation: all state returns to reset values on the next edge. Table contents written since the last reset are cleared.
- WR_ACK latency is 1 cycle. There is no backpressure; a write can be accepted every cycle.

## Structure
- skip_pkg holds:
  - LEN, DEPTH and INIT_MASK defaults;
  - the state enum {RESYNC, RUN};
  - the index width function clog2(DEPTH).
- One sub-module, skip_prescale: counter, SLOW_CLK and TICK, with ports CLK, RST, DIV_SEL, SLOW_CLK, TICK.
- FSM, table and dwell counter live in skip_seq.

## Test plan
- Reset release, DIV_SEL=2, DWELL=0:
  - First TICK at cycle 5, then every 8 cycles.
  - RING_RST drops 1 cycle after the first TICK.
  - MASK stays 16'h3445 forever.
- Write entry 1 = 16'h00FF, DIV_SEL=0, DWELL=3:
  - After the 4th TICK (1 resync + 3 dwell): IDX=1, MASK=16'h00FF, RING_RST=1 for exactly one slow period.
- DWELL=1, DEPTH=4:
  - IDX sequence is 0,1,2,3,0.
  - MASK on wrap equals entry 0 (16'h3445).
- Write to the active entry mid-dwell: MASK unchanged until the next selection.
- Write and advance to the same entry on the same edge: the newly written value appears on MASK.
- Assert RST during RUN with IDX=2: next cycle IDX=0, MASK=16'h3445, RING_RST=1, entries 1–3 read back 0.
